// File: rtl/multi_chan_disp_pkg.sv
// Shared types and reset constants for the multi-channel display block.
// Holds the scan-state enum and the reset values used by the capture and
// output registers.
package multi_chan_disp_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } scan_state_t;

    // Power-on pattern shown on the display before anything is captured.
    localparam logic [31:0] RST_DATA_DEF = 32'hAA5555AA;
    // Each blink-enable bit resets to 1 and each point bit resets to 0.
    localparam logic        BLINK_RST    = 1'b1;
    localparam logic        POINT_RST    = 1'b0;

endpackage

// File: rtl/multi_chan_disp_scan_timer.sv
// scan_timer: dwell counter for auto-scan.
// While run=1 the counter increments on each edge. tick is high
// (combinationally) in the cycle where the counter holds DWELL-1, and that
// same edge clears the counter. With run=0 the counter clears and tick stays
// low, so every new run starts a full dwell period.
// Ports: clk, rst (async active-high), run (count enable), tick (advance strobe).
module scan_timer
    import multi_chan_disp_pkg::*;
#(
    parameter int DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);
    localparam int              CW   = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    assign tick = run && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (!run || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/multi_chan_disp.sv
// multi_chan_disp: selects one of NCH display channels onto registered outputs.
// Channel 0 is taken from capture registers loaded on EN; the other channels
// pass their input slices straight to the output mux. The shown channel is
// chosen by sel (manual) or, when built with MULTI_CHAN_DISP_AUTOSCAN_EN, by
// an auto-scan that advances every DWELL cycles while auto=1.
// Ports:
//   clk, rst        clock, async active-high reset
//   EN              capture strobe for channel-0 data/point/blink
//   sel, auto       manual channel select, auto-scan request
//   data_in, point_in, LES   packed per-channel inputs (channel c at c*W)
//   Disp_num, point_out, LE_out   registered outputs of the current channel
//   cur_ch          registered current channel index
//   scan_tick       one-cycle pulse, coincident with each auto-scan advance
// Build macro: MULTI_CHAN_DISP_AUTOSCAN_EN enables the auto-scan FSM and timer.
module multi_chan_disp
    import multi_chan_disp_pkg::*;
#(
    parameter int          NCH      = 8,
    parameter int          DW       = 32,
    parameter int          PW       = 8,
    parameter int          DWELL    = 50_000_000,
    parameter logic [31:0] RST_DATA = RST_DATA_DEF,
    localparam int         SW       = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic [SW-1:0]     sel,
    input  logic              auto,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH*PW-1:0] point_in,
    input  logic [NCH*PW-1:0] LES,
    output logic [DW-1:0]     Disp_num,
    output logic [PW-1:0]     point_out,
    output logic [PW-1:0]     LE_out,
    output logic [SW-1:0]     cur_ch,
    output logic              scan_tick
);
    localparam logic [DW-1:0] RST_VAL = DW'(RST_DATA);

    logic [DW-1:0] r_cap_data, r_disp, w_mux_data;
    logic [PW-1:0] r_cap_pt, r_cap_le, r_pt, r_le, w_mux_pt, w_mux_le;
    logic [SW-1:0] r_cur_ch;
    logic          w_sel_ok;

    // sel values naming a non-existent channel leave cur_ch unchanged.
    assign w_sel_ok = (32'(sel) < NCH);

    // Output mux: channel 0 is the capture registers, others are live slices.
    always_comb begin
        w_mux_data = r_cap_data;
        w_mux_pt   = r_cap_pt;
        w_mux_le   = r_cap_le;
        for (int c = 1; c < NCH; c++) begin
            if (r_cur_ch == SW'(c)) begin
                w_mux_data = data_in[c*DW +: DW];
                w_mux_pt   = point_in[c*PW +: PW];
                w_mux_le   = LES[c*PW +: PW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_data <= RST_VAL;
            r_cap_le   <= {PW{BLINK_RST}};
            r_cap_pt   <= {PW{POINT_RST}};
            r_disp     <= RST_VAL;
            r_le       <= {PW{BLINK_RST}};
            r_pt       <= {PW{POINT_RST}};
        end else begin
            if (EN) begin
                r_cap_data <= data_in[DW-1:0];
                r_cap_pt   <= point_in[PW-1:0];
                r_cap_le   <= LES[PW-1:0];
            end
            r_disp <= w_mux_data;
            r_pt   <= w_mux_pt;
            r_le   <= w_mux_le;
        end
    end

`ifdef MULTI_CHAN_DISP_AUTOSCAN_EN
    scan_state_t   r_state;
    logic          r_scan_tick;
    logic          w_run, w_tick;
    logic [SW-1:0] w_next_ch;

    // Counting stops on the exit edge so leaving AUTO never fires a tick.
    assign w_run     = (r_state == AUTO) && auto;
    assign w_next_ch = (r_cur_ch == SW'(NCH - 1)) ? '0 : r_cur_ch + 1'b1;

    scan_timer #(.DWELL(DWELL)) u_scan_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= MANUAL;
            r_cur_ch    <= '0;
            r_scan_tick <= 1'b0;
        end else begin
            r_scan_tick <= 1'b0;
            case (r_state)
                MANUAL: begin
                    if (auto)
                        r_state <= AUTO;
                    else if (w_sel_ok)
                        r_cur_ch <= sel;
                end
                AUTO: begin
                    if (!auto) begin
                        r_state <= MANUAL;
                        if (w_sel_ok)
                            r_cur_ch <= sel;
                    end else if (w_tick) begin
                        r_cur_ch    <= w_next_ch;
                        r_scan_tick <= 1'b1;
                    end
                end
                default: r_state <= MANUAL;
            endcase
        end
    end

    assign scan_tick = r_scan_tick;
`else
    logic w_unused_auto;
    assign w_unused_auto = auto;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cur_ch <= '0;
        else if (w_sel_ok)
            r_cur_ch <= sel;
    end

    assign scan_tick = 1'b0;
`endif

    assign Disp_num  = r_disp;
    assign point_out = r_pt;
    assign LE_out    = r_le;
    assign cur_ch    = r_cur_ch;
endmodule

// File: tb/tb_multi_chan_disp.sv
// Bench for multi_chan_disp with NCH=5, DWELL=4: directed literal checks plus
// a randomized run compared every cycle against a behavioural model.
module tb_multi_chan_disp;
    localparam int NCH = 5, DW = 32, PW = 8, DWELL = 4, SW = 3;

    logic              clk = 1'b0, rst, EN, auto;
    logic [SW-1:0]     sel;
    logic [NCH*DW-1:0] data_in;
    logic [NCH*PW-1:0] point_in, LES;
    logic [DW-1:0]     Disp_num;
    logic [PW-1:0]     point_out, LE_out;
    logic [SW-1:0]     cur_ch;
    logic              scan_tick;

    int n_chk = 0, n_pass = 0;
    bit mdl_on = 1'b0;

    multi_chan_disp #(.NCH(NCH), .DW(DW), .PW(PW), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .EN(EN), .sel(sel), .auto(auto),
        .data_in(data_in), .point_in(point_in), .LES(LES),
        .Disp_num(Disp_num), .point_out(point_out), .LE_out(LE_out),
        .cur_ch(cur_ch), .scan_tick(scan_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // m_n counts edges spent in AUTO since entry; every DWELL-th one advances.
    logic [DW-1:0] m_cap_d, m_disp;
    logic [PW-1:0] m_cap_pt, m_cap_le, m_pt, m_le;
    int  m_ch, m_n;
    bit  m_auto, m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cap_d = 32'hAA5555AA; m_cap_le = '1; m_cap_pt = '0;
            m_disp  = 32'hAA5555AA; m_le     = '1; m_pt     = '0;
            m_ch = 0; m_n = 0; m_auto = 0; m_tick = 0;
        end else begin
            if (m_ch == 0) begin
                m_disp = m_cap_d; m_pt = m_cap_pt; m_le = m_cap_le;
            end else begin
                m_disp = data_in[m_ch*DW +: DW];
                m_pt   = point_in[m_ch*PW +: PW];
                m_le   = LES[m_ch*PW +: PW];
            end
            if (EN) begin
                m_cap_d = data_in[DW-1:0]; m_cap_pt = point_in[PW-1:0]; m_cap_le = LES[PW-1:0];
            end
            m_tick = 0;
`ifdef MULTI_CHAN_DISP_AUTOSCAN_EN
            if (!m_auto) begin
                if (auto) begin m_auto = 1; m_n = 0; end
                else if (int'(sel) < NCH) m_ch = int'(sel);
            end else if (!auto) begin
                m_auto = 0;
                if (int'(sel) < NCH) m_ch = int'(sel);
            end else begin
                m_n++;
                if (m_n % DWELL == 0) begin m_ch = (m_ch + 1) % NCH; m_tick = 1; end
            end
`else
            if (int'(sel) < NCH) m_ch = int'(sel);
`endif
        end
    end

    always @(negedge clk) begin
        if (mdl_on && !rst) begin
            chk("model Disp_num",  64'(Disp_num),  64'(m_disp));
            chk("model point_out", 64'(point_out), 64'(m_pt));
            chk("model LE_out",    64'(LE_out),    64'(m_le));
            chk("model cur_ch",    64'(cur_ch),    64'(m_ch));
            chk("model scan_tick", 64'(scan_tick), 64'(m_tick));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Disp_num"},  64'(Disp_num),  64'h0AA5555AA);
        chk({tag, " LE_out"},    64'(LE_out),    64'hFF);
        chk({tag, " point_out"}, 64'(point_out), 64'h00);
        chk({tag, " cur_ch"},    64'(cur_ch),    64'd0);
        chk({tag, " scan_tick"}, 64'(scan_tick), 64'd0);
    endtask

    task automatic rand_inputs();
        for (int c = 0; c < NCH; c++) begin
            data_in[c*DW +: DW] = $urandom;
            point_in[c*PW +: PW] = 8'($urandom);
            LES[c*PW +: PW] = 8'($urandom);
        end
    endtask

    int exp_ch[16] = '{3,3,3,4,4,4,4,0,0,0,0,1,1,1,1,2};

    initial begin
        rst = 1'b1; EN = 1'b0; auto = 1'b0; sel = '0;
        data_in = '0; point_in = '0; LES = '0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        mdl_on = 1'b1;

        // Capture on channel 0
        data_in[31:0] = 32'h12345678; point_in[7:0] = 8'h5A; LES[7:0] = 8'h0F; EN = 1'b1;
        step();
        EN = 1'b0; data_in[31:0] = 32'hCAFEF00D; point_in[7:0] = 8'h11; LES[7:0] = 8'h22;
        step();
        chk("capture Disp_num",  64'(Disp_num),  64'h12345678);
        chk("capture point_out", 64'(point_out), 64'h5A);
        chk("capture LE_out",    64'(LE_out),    64'h0F);
        step();
        chk("capture held", 64'(Disp_num), 64'h12345678);

        // Manual select, including out-of-range sel
        sel = 3'd3; data_in[3*DW +: DW] = 32'hDEADBEEF;
        step();
        chk("manual cur_ch", 64'(cur_ch), 64'd3);
        step();
        chk("manual Disp_num", 64'(Disp_num), 64'hDEADBEEF);
        sel = 3'd7;
        step();
        chk("sel7 ignored", 64'(cur_ch), 64'd3);
        sel = 3'd5;
        step();
        chk("sel5 ignored", 64'(cur_ch), 64'd3);

`ifdef MULTI_CHAN_DISP_AUTOSCAN_EN
        // Auto-scan from channel 3 with wrap 4 -> 0
        auto = 1'b1;
        step();
        chk("auto entry cur_ch", 64'(cur_ch), 64'd3);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("auto k%0d cur_ch", k), 64'(cur_ch), 64'(exp_ch[k-1]));
            chk($sformatf("auto k%0d tick", k), 64'(scan_tick), 64'((k % 4) == 0));
        end
        // Two dwell cycles, then exit with sel=1
        step(); step();
        sel = 3'd1; auto = 1'b0;
        step();
        chk("exit cur_ch", 64'(cur_ch), 64'd1);
        chk("exit tick", 64'(scan_tick), 64'd0);
        // Re-entry restarts a full dwell count
        auto = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("reentry k%0d cur_ch", k), 64'(cur_ch), 64'd1);
        end
        step();
        chk("reentry adv cur_ch", 64'(cur_ch), 64'd2);
        chk("reentry adv tick", 64'(scan_tick), 64'd1);
        auto = 1'b0;
        step();
`else
        // auto is ignored: cur_ch follows sel, scan_tick stays low
        auto = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sel = 3'($urandom_range(0, NCH - 1));
            step();
            chk($sformatf("noauto k%0d cur_ch", k), 64'(cur_ch), 64'(sel));
            chk($sformatf("noauto k%0d tick", k), 64'(scan_tick), 64'd0);
        end
        auto = 1'b0;
`endif

        // Randomized run against the model, with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            EN  = ($urandom_range(0, 2) == 0);
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) auto = ~auto;
            if (i == 200) begin
                auto = 1'b1;
                #3 rst = 1'b1;
                #1 chk_reset_vals("midrun reset");
                @(negedge clk);
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
